// File: rtl/fpmul_sched_pkg.sv
// Shared types, widths and the round-robin pick helper for the FP multiplier scheduler.
package fpmul_sched_pkg;

  localparam int unsigned FP_W    = 32;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned PTR_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // One-hot winner: first set bit of valid_vec searching upward from ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] onehot;
    logic               found;
    logic [PTR_W-1:0]   idx;
    onehot = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % n);
      if (!found && (i < n) && valid_vec[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/fpmul_rr_arbiter.sv
// Combinational round-robin arbiter.
//   valid     : per-requester request vector
//   ptr       : highest-priority requester index
//   grant     : one-hot winner (zero when nothing is valid)
//   grant_idx : encoded winner index
//   any_grant : a winner exists
module fpmul_rr_arbiter
  import fpmul_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  logic [MAX_REQ-1:0] pick;

  always_comb begin
    pick      = rr_pick(MAX_REQ'(valid), PTR_W'(ptr), NUM_REQ);
    grant     = pick[NUM_REQ-1:0];
    any_grant = |pick;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) grant_idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/fpmul_rr_scheduler.sv
// Round-robin scheduler sharing one combinational FP multiplier between NUM_REQ clients.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : per-requester handshake (req_ready one-hot, IDLE only)
//   req_a/req_b               : packed operands, requester i at [32*i +: 32]
//   mul_a/mul_b, mul_result   : registered operands to / product from the multiplier
//   rsp_valid/rsp_ready       : response handshake; rsp_data/rsp_id hold product and owner
//   busy                      : high whenever the FSM is not in IDLE
// Optional build macro FPMUL_PERF_CNT_EN adds saturating counters perf_ops and perf_busy.
module fpmul_rr_scheduler
  import fpmul_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [FP_W-1:0]         mul_a,
  output logic [FP_W-1:0]         mul_b,
  input  logic [FP_W-1:0]         mul_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FP_W-1:0]         rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
`ifdef FPMUL_PERF_CNT_EN
  ,
  output logic [31:0]             perf_ops,
  output logic [31:0]             perf_busy
`endif
);

  localparam int unsigned CNT_W = 4;

  state_e             state, state_d;
  logic [ID_W-1:0]    rr_ptr, cur_id, win_idx;
  logic [NUM_REQ-1:0] grant;
  logic               win_any;
  logic [CNT_W-1:0]   wait_cnt;
  logic [FP_W-1:0]    sel_a, sel_b;
  logic               issue, accept;

  fpmul_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (win_idx),
    .any_grant (win_any)
  );

  // Grant is only offered while idle; a valid winner in IDLE is the handshake.
  assign req_ready = (state == IDLE) ? grant : '0;
  assign issue     = (state == IDLE) && win_any;
  assign accept    = (state == RESP) && rsp_ready;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*FP_W +: FP_W];
        sel_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (win_any) state_d = WAIT;
      WAIT:    if (wait_cnt == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Operand capture, settle counter, response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cur_id    <= '0;
      wait_cnt  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      if (issue) begin
        mul_a    <= sel_a;
        mul_b    <= sel_b;
        cur_id   <= win_idx;
        rr_ptr   <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        wait_cnt <= CNT_W'(MUL_LAT - 1);
      end
      if (state == WAIT) begin
        if (wait_cnt == '0) begin
          rsp_valid <= 1'b1;
          rsp_data  <= mul_result;
          rsp_id    <= cur_id;
        end else begin
          wait_cnt <= wait_cnt - CNT_W'(1);
        end
      end
      if (accept) rsp_valid <= 1'b0;
    end
  end

`ifdef FPMUL_PERF_CNT_EN
  // Saturating counters; an op occupies the multiplier from its grant cycle onward,
  // so the grant cycle is counted together with the busy cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (accept && (perf_ops != '1))           perf_ops  <= perf_ops + 32'd1;
      if ((busy || issue) && (perf_busy != '1)) perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpmul_rr_scheduler.sv
// Scoreboard bench for fpmul_rr_scheduler with a table-driven multiplier model.
module tb_fpmul_rr_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned MUL_LAT = 1;
  localparam int          EXP_LAT = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*32-1:0]   req_a, req_b;
  logic [31:0]             mul_a, mul_b, mul_result;
  logic                    rsp_valid, rsp_ready;
  logic [31:0]             rsp_data;
  logic [ID_W-1:0]         rsp_id;
  logic                    busy;
`ifdef FPMUL_PERF_CNT_EN
  logic [31:0]             perf_ops, perf_busy;
`endif

  typedef struct {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
  } rsp_t;

  int          gq[$];
  rsp_t        rq[$];
  int          tests = 0;
  int          fails = 0;
  int          pend [NUM_REQ];
  logic [31:0] op_a [NUM_REQ];
  logic [31:0] op_b [NUM_REQ];

  always #5 clk = ~clk;

  fpmul_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef FPMUL_PERF_CNT_EN
    ,
    .perf_ops   (perf_ops),
    .perf_busy  (perf_busy)
`endif
  );

  // Multiplier model: products of the operand pairs used below, quiet NaN otherwise.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3FC00000, 32'hC0400000}: return 32'hC0900000;
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'h3F000000, 32'h40000000}: return 32'h3F800000;
      default:                      return 32'h7FC00000;
    endcase
  endfunction

  assign mul_result = fmul(mul_a, mul_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]       = (pend[i] > 0);
      req_a[i*32 +: 32]  = op_a[i];
      req_b[i*32 +: 32]  = op_b[i];
    end
  endtask

  // One clock: note handshakes before the edge, update requesters just after it.
  task automatic step();
    logic [NUM_REQ-1:0] hs;
    @(negedge clk);
    hs = rst ? '0 : (req_valid & req_ready);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (hs[i] && pend[i] > 0) pend[i]--;
    apply();
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < NUM_REQ; i++) if (pend[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    step();
    while ((any_pend() || busy || rsp_valid) && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input int cnt);
    op_a[i] = a;
    op_b[i] = b;
    pend[i] = cnt;
  endtask

  task automatic exp_op(input int id, input logic [31:0] data);
    rsp_t r;
    r.data = data;
    r.id   = ID_W'(id);
    gq.push_back(id);
    rq.push_back(r);
  endtask

  // Monitor: grant order, grant-to-response latency, response payloads.
  int   cyc = 0;
  int   gcyc = 0;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] hs;
    int   gi;
    int   e;
    rsp_t r;
    cyc++;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      hs = req_valid & req_ready;
      if (hs != '0) begin
        gi = 0;
        for (int i = 0; i < NUM_REQ; i++) if (hs[i]) gi = i;
        check("grant_onehot", 32'($countones(hs)), 32'd1);
        if (gq.size() == 0) begin
          tests++; fails++;
          $display("FAIL grant_unexpected: got grant %0d expected none", gi);
        end else begin
          e = gq.pop_front();
          check("grant_id", 32'(gi), 32'(e));
        end
        gcyc = cyc;
      end
      if (rsp_valid && !prev_v) check("rsp_latency", 32'(cyc - gcyc), 32'(EXP_LAT));
      if (rsp_valid && rsp_ready) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp_unexpected: got data %h id %0d expected none", rsp_data, rsp_id);
        end else begin
          r = rq.pop_front();
          check("rsp_data", rsp_data, r.data);
          check("rsp_id", 32'(rsp_id), 32'(r.id));
        end
      end
      prev_v = rsp_valid;
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h0, 32'h0, 0);
    apply();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // 1.5 * -3.0 on requester 0
    set_op(0, 32'h3FC00000, 32'hC0400000, 1);
    apply();
    exp_op(0, 32'hC0900000);
    wait_idle("t1");
    check("t1_mul_a_hold", mul_a, 32'h3FC00000);
    check("t1_mul_b_hold", mul_b, 32'hC0400000);

    // Fresh pointer, all four requesting; requester 0 wants two ops
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h40000000, 32'h40400000, (i == 0) ? 2 : 1);
    apply();
    exp_op(0, 32'h40C00000);
    exp_op(1, 32'h40C00000);
    exp_op(2, 32'h40C00000);
    exp_op(3, 32'h40C00000);
    exp_op(0, 32'h40C00000);
    wait_idle("t2");

    // Backpressure on a req0 op while req1 waits behind it
    rsp_ready = 1'b0;
    set_op(0, 32'h40000000, 32'h40400000, 1);
    apply();
    exp_op(0, 32'h40C00000);
    exp_op(1, 32'hC0900000);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    check("t3_rsp_seen", 32'(rsp_valid), 32'd1);
    set_op(1, 32'h3FC00000, 32'hC0400000, 1);
    apply();
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", 32'(rsp_valid), 32'd1);
      check("t3_hold_data", rsp_data, 32'h40C00000);
      check("t3_hold_id", 32'(rsp_id), 32'd0);
      check("t3_no_grant", 32'(req_ready), 32'd0);
      check("t3_busy", 32'(busy), 32'd1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("t3_idle_busy", 32'(busy), 32'd0);
    check("t3_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t3_next_grant", 32'(req_ready), 32'b0010);
    wait_idle("t3");

    // Requester 2 op moves the pointer to 3, then 1 and 3 contend
    set_op(2, 32'h3F000000, 32'h40000000, 1);
    apply();
    exp_op(2, 32'h3F800000);
    wait_idle("t4a");
    set_op(1, 32'h3FC00000, 32'hC0400000, 1);
    set_op(3, 32'h40000000, 32'h40400000, 1);
    apply();
    exp_op(3, 32'h40C00000);
    exp_op(1, 32'hC0900000);
    wait_idle("t4");

    // Reset while waiting on the multiplier discards the op
    set_op(0, 32'h3FC00000, 32'hC0400000, 1);
    apply();
    gq.push_back(0);
    n = 0;
    while (!busy && n < 20) begin step(); n++; end
    check("t5_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_mul_a", mul_a, 32'd0);
    check("t5_mul_b", mul_b, 32'd0);
    check("t5_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;
    set_op(2, 32'h3F000000, 32'h40000000, 1);
    apply();
    exp_op(2, 32'h3F800000);
    wait_idle("t5");

`ifdef FPMUL_PERF_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_op(0, 32'h40000000, 32'h40400000, 3);
    apply();
    exp_op(0, 32'h40C00000);
    exp_op(0, 32'h40C00000);
    exp_op(0, 32'h40C00000);
    wait_idle("t6");
    check("t6_perf_ops", perf_ops, 32'd3);
    check("t6_perf_busy", perf_busy, 32'd9);
`endif

    repeat (4) step();
    check("end_grant_queue", 32'(gq.size()), 32'd0);
    check("end_rsp_queue", 32'(rq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
